data_memory: RTL
================

// Module: data_memory
// PURPOSE
//  Main-memory responder behind the data cache. It serves the cache's memory-side
//  requests: address, write enable, 4-byte data and byte mode. Each request
//  completes after a fixed latency and is acknowledged with a one-cycle ready pulse.
//  Word-organised, byte-lane addressable backing store. Sits between the cache
//  miss/writeback path and the top level.
// PARAMETERS
//  DEPTH_WORDS  1024  number of 32-bit words; power of two
//  LATENCY      4     cycles from request acceptance to ready pulse; must be >= 1
//  BLOCK_WORDS  4     words per cache block; used only with MEM_BURST_EN; power of two
// PORTS
//  clk           in   1       clock; rising edge
//  reset         in   1       asynchronous reset, active-low
//  mem_addr      in   32      byte address of the request
//  data_in       in   8x4     write data; lane i = byte at address offset i
//  byte_mode     in   1       1: single-byte access; 0: aligned word access
//  write_enable  in   1       1: write request; 0: read request
//  enable        in   1       request valid
//  data_out      out  8x4     read data; valid while ready=1
//  ready         out  1       one-cycle completion pulse
//  burst         in   1       block-refill read request (MEM_BURST_EN only)
//  burst_last    out  1       marks final beat of a burst (MEM_BURST_EN only)
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE, ready=0, data_out=0, counter=0,
//    burst_last=0. The array is not cleared. A pending request is aborted and
//    performs no write.
//  - FSM states and transitions:
//    - IDLE: on a rising edge with enable=1, latch addr/data/write_enable/byte_mode,
//      load counter=LATENCY-1 and go to WAIT. With LATENCY=1, go directly to RESP.
//    - WAIT: decrement the counter each cycle; at counter==1, go to RESP.
//    - RESP: ready=1 for exactly this cycle, then go to IDLE.
//  - Timing: ready is high in the LATENCY-th cycle after the accepting edge.
//    Minimum request spacing is LATENCY+1 cycles.
//  - Inputs are ignored outside IDLE. Dropping enable mid-request still completes
//    the latched request.
//  - Word index = addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored,
//    so addresses wrap modulo the memory size.
//  - Word mode: addr[1:0] is ignored. A write stores all 4 lanes; a read returns
//    all 4 lanes.
//  - Byte mode, write: only lane addr[1:0] is written, using data_in[0].
//  - Byte mode, read: data_out[0] = selected byte; data_out[1..3] = 0.
//  - The write commits on the edge entering RESP.
//  - A write response leaves data_out unchanged; only ready pulses.
//  - Reads are registered: data_out is loaded on the edge entering RESP and holds
//    until the next read completes.
// CONFIGURATION
//  MEM_BURST_EN defined:
//  - A request with burst=1 is a word read of BLOCK_WORDS consecutive words,
//    starting at the block-aligned address (addr with the low log2(BLOCK_WORDS)+2
//    bits cleared). write_enable and byte_mode are ignored.
//  - Beat 0 arrives after LATENCY cycles; each further beat follows on the next
//    cycle. ready=1 on every beat.
//  - burst_last=1 only on the final beat; then go to IDLE.
//  - This adds a BURST state and a beat counter.
//  MEM_BURST_EN undefined:
//  - The burst and burst_last ports do not exist. Single accesses only.
// STRUCTURE
//  - Package mem_pkg: typedef byte_t (logic [7:0]); typedef word_t
//    (byte_t [0:3]); enum mem_state_t {IDLE, WAIT, RESP, BURST}; constant
//    WORD_BYTES = 4.
//  - Sub-module mem_latency_timer: loadable down-counter with load, tick and
//    a done flag (done when count==1). The FSM and storage array stay in
//    data_memory.
// TESTING
//  1. Word write 0xDEADBEEF to 0x10, then word read of 0x10: ready at +4 cycles
//     each; data_out = {EF,BE,AD,DE} (lane0 = EF).
//  2. Byte write 0x5A to 0x13 over that word, then word read: lanes = {EF,BE,AD,5A}.
//     Byte read of 0x11: data_out = {BE,00,00,00}.
//  3. Drop enable 1 cycle after acceptance: ready still pulses exactly once, at +4.
//     A second enable during WAIT is ignored.
//  4. Assert reset at +2 of a write to 0x20: ready stays 0. A later read of 0x20
//     returns the old contents.
//  5. Write to 0x1000 with DEPTH_WORDS=1024, then read 0x0: returns the written
//     data (wrap-around).
//  6. MEM_BURST_EN: burst read at 0x34 (block 0x30): 4 consecutive ready beats
//     starting at +4, words 0x30..0x3C, burst_last on the 4th beat only.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the data-memory responder: byte/word lane types and FSM states.
package mem_pkg;
   typedef logic [7:0] byte_t;
   typedef byte_t [0:3] word_t;
   typedef enum logic [1:0] {IDLE, WAIT, RESP, BURST} mem_state_t;
   localparam int unsigned WORD_BYTES = 4;
endpackage

// File: rtl/mem_latency_timer.sv
// Loadable down-counter; o_done flags the last waiting cycle (count == 1).
module mem_latency_timer #(
   parameter int unsigned W = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_value,
   input  logic         i_tick,
   output logic         o_done
);
   logic [W-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_count <= '0;
      else if (i_load)
         r_count <= i_value;
      else if (i_tick && (r_count != '0))
         r_count <= r_count - 1'b1;
   end

   assign o_done = (r_count == W'(1));
endmodule

// File: rtl/data_memory.sv
// Fixed-latency main-memory responder with byte-lane writes and byte/word reads.
// Optional block-refill burst reads are enabled with `define MEM_BURST_EN.
module data_memory
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 4,
   parameter int unsigned BLOCK_WORDS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] mem_addr,
   input  word_t       data_in,
   input  logic        byte_mode,
   input  logic        write_enable,
   input  logic        enable,
`ifdef MEM_BURST_EN
   input  logic        burst,
   output logic        burst_last,
`endif
   output word_t       data_out,
   output logic        ready
);
   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
   localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   mem_state_t       r_state;
   logic [IDX_W+1:0] r_addr;
   word_t            r_wdata;
   logic             r_we;
   logic             r_bm;
   word_t            r_data_out;
   word_t            r_mem [DEPTH_WORDS];

   logic             w_idle;
   logic             w_accept;
   logic             w_fire;
   logic             w_timer_done;
   logic             w_we;
   logic             w_bm;
   logic             w_burst;
   logic             w_burst_done;
   logic             w_do_write;
   logic             w_load_rd;
   logic [IDX_W+1:0] w_addr;
   word_t            w_wdata;
   logic [IDX_W-1:0] w_idx;
   logic [IDX_W-1:0] w_rd_idx;
   logic [1:0]       w_lane;
   word_t            w_rd_word;
   mem_state_t       w_resp_state;
   logic             w_unused;

   assign w_unused = ^mem_addr[31:IDX_W+2];

   assign w_idle   = (r_state == IDLE);
   assign w_accept = w_idle && enable;

   // In IDLE the live inputs are used so a LATENCY of 1 can complete on the accepting edge.
   assign w_addr  = w_idle ? mem_addr[IDX_W+1:0] : r_addr;
   assign w_wdata = w_idle ? data_in : r_wdata;
   assign w_we    = w_idle ? write_enable : r_we;
   assign w_bm    = w_idle ? byte_mode : r_bm;
   assign w_idx   = w_addr[IDX_W+1:2];
   assign w_lane  = w_addr[1:0];

`ifdef MEM_BURST_EN
   localparam int unsigned      BLK_W    = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
   localparam logic [IDX_W-1:0] BLK_MASK = IDX_W'(BLOCK_WORDS - 1);

   logic             r_burst;
   logic [BLK_W-1:0] r_beat;
   logic [BLK_W-1:0] w_next_beat;

   assign w_burst      = w_idle ? burst : r_burst;
   assign w_burst_done = (r_state == BURST) && (r_beat == BLK_W'(BLOCK_WORDS - 1));
   assign w_next_beat  = (r_state == BURST) ? (r_beat + 1'b1) : '0;
   assign w_rd_idx     = w_burst ? ((w_idx & ~BLK_MASK) | IDX_W'(w_next_beat)) : w_idx;
   assign burst_last   = w_burst_done;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_burst <= 1'b0;
         r_beat  <= '0;
      end else if (w_accept) begin
         r_burst <= burst;
         r_beat  <= '0;
      end else if (r_state == BURST) begin
         r_beat  <= w_next_beat;
      end
   end
`else
   assign w_burst      = 1'b0;
   assign w_burst_done = 1'b1;
   assign w_rd_idx     = w_idx;
`endif

   assign w_resp_state = w_burst ? BURST : RESP;

   mem_latency_timer #(.W(CNT_W)) u_timer (
      .clk     (clk),
      .rst_n   (reset),
      .i_load  (w_accept),
      .i_value (CNT_W'(LATENCY - 1)),
      .i_tick  (r_state == WAIT),
      .o_done  (w_timer_done)
   );

   assign w_fire     = reset && ((w_accept && (LATENCY == 1)) || ((r_state == WAIT) && w_timer_done));
   assign w_do_write = w_fire && w_we && !w_burst;
   assign w_load_rd  = (w_fire && (!w_we || w_burst)) || ((r_state == BURST) && !w_burst_done);

   always_comb begin
      w_rd_word = r_mem[w_rd_idx];
      if (w_bm && !w_burst) begin
         w_rd_word    = '0;
         w_rd_word[0] = r_mem[w_idx][w_lane];
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_write) begin
         if (w_bm)
            r_mem[w_idx][w_lane] <= w_wdata[0];
         else
            r_mem[w_idx] <= w_wdata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_we       <= 1'b0;
         r_bm       <= 1'b0;
         r_data_out <= '0;
      end else begin
         if (w_load_rd)
            r_data_out <= w_rd_word;
         case (r_state)
            IDLE: begin
               if (enable) begin
                  r_addr  <= w_addr;
                  r_wdata <= data_in;
                  r_we    <= write_enable;
                  r_bm    <= byte_mode;
                  r_state <= (LATENCY == 1) ? w_resp_state : WAIT;
               end
            end
            WAIT:    if (w_timer_done) r_state <= w_resp_state;
            RESP:    r_state <= IDLE;
            BURST:   if (w_burst_done) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign ready    = (r_state == RESP) || (r_state == BURST);
   assign data_out = r_data_out;
endmodule
